ex_issue_ctrl: RTL

EX-stage consumer of the ID/EX pipeline register in the milano core. Accepts one instruction per cycle from ID/EX. Single-cycle ops pass straight to the EX/WB boundary. RV32M MUL/DIV ops hold EX for a fixed multi-cycle latency and back-pressure ID/EX with a stall. Flush discards in-flight work.

---
 rtl/ex_issue_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - EX-stage issue control: single-cycle pass-through, multi-cycle RV32M hold with stall
// Optional stall counter output enabled by defining EX_PERF_CNT_EN.
module ex_issue_ctrl #(
  parameter int          MULDIV_LAT = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        flush_i,
`ifdef EX_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic        stall_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        busy_o
);

  localparam int CW = $clog2(MULDIV_LAT) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   r_held;
  logic [31:0]   w_held_next;
  logic [31:0]   r_instr;
  logic [31:0]   w_instr_next;
  logic          r_valid;
  logic          w_valid_next;
  logic          w_muldiv;

  assign w_muldiv = (instr_i[6:0] == 7'b0110011) && (instr_i[31:25] == 7'b0000001);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_held  <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_held  <= w_held_next;
      r_instr <= w_instr_next;
      r_valid <= w_valid_next;
    end
  end

  // Output defaults to a bubble; only an accepted single-cycle op or a completion overrides it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_held_next  = r_held;
    w_instr_next = NOP_INSTR;
    w_valid_next = 1'b0;
    if (flush_i) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_held_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid_i) begin
            if (w_muldiv) begin
              w_held_next  = instr_i;
              w_cnt_next   = CW'(MULDIV_LAT - 1);
              w_state_next = S_BUSY;
            end else begin
              w_instr_next = instr_i;
              w_valid_next = 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
          end else begin
            w_instr_next = r_held;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign stall_o       = (r_state == S_BUSY);
  assign busy_o        = stall_o;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;

`ifdef EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Flush deliberately leaves this untouched; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (stall_o) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
